instr_queue: RTL
================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter FETCH_W, default 2, lanes per bundle in and out.
REQ-002 SHALL have parameter PC_W, default 32, PC width.
REQ-003 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-004 SHALL have parameter DEPTH, default 8, entry count; must be a power of 2 and at least 4*FETCH_W.
REQ-005 SHALL have one clock and a synchronous, active-high reset; ports below.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 if_valid  input  FETCH_W  per-lane valid of the fetch bundle.
REQ-009 if_pc  input  FETCH_W x PC_W  per-lane PC.
REQ-010 if_instr  input  FETCH_W x INSTR_W  per-lane instruction.
REQ-011 flush  input  1  redirect/flush; discard all contents.
REQ-012 fq_stall  output  1  backpressure to fetch stall input.
REQ-013 dq_valid  output  FETCH_W  per-lane valid toward decode.
REQ-014 dq_pc  output  FETCH_W x PC_W  head entries' PCs, oldest in lane 0.
REQ-015 dq_instr  output  FETCH_W x INSTR_W  head entries' instructions.
REQ-016 dec_accept  input  FETCH_W  decode consumes lane; lane i counts only if lanes 0..i all accepted and valid.
REQ-017 ovf_err  output  1  sticky: an input lane was dropped for lack of space.

Function
REQ-018 SHALL be a circular FIFO with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, and a count of 0..DEPTH.
REQ-019 SHALL compact valid input lanes in lane order: e.g. if_valid=2'b10 writes lane 1 only, into the tail slot.
REQ-020 SHALL enqueue up to FETCH_W and dequeue up to FETCH_W entries in the same cycle: count_next = count + enq - deq.
REQ-021 SHALL drive dq_valid[i]=1 iff count > i; dq_pc/dq_instr lane i come from slot head+i (fall-through read).
REQ-022 SHALL mask dec_accept: deq = number of leading contiguous lanes with dq_valid & dec_accept; a gap ends the count.
REQ-023 SHALL drive fq_stall = (count > DEPTH - 2*FETCH_W), decoded from registered count only, reserving space for two in-flight bundles.
REQ-024 SHALL, when free space after dequeue is less than the valid lanes, write the lanes that fit in lane order, drop the rest, and set ovf_err.
REQ-025 SHALL, when flush=1, set count, head and tail to 0 on the next edge, ignore that cycle's enqueue and dequeue, and leave ovf_err unchanged.
REQ-026 SHALL give 1-cycle latency from if_valid into an empty queue to dq_valid (without REQ-030).
REQ-027 SHALL allow full-then-empty in one cycle: at count=DEPTH, dequeueing FETCH_W and enqueueing FETCH_W keeps count=DEPTH.

Reset
REQ-028 SHALL, on reset, set count=0, head=0, tail=0, ovf_err=0, giving dq_valid=0 and fq_stall=0; storage contents are not reset.
REQ-029 SHALL give reset priority over flush, enqueue and dequeue, including mid-operation at any count.

Configuration
REQ-030 SHALL, with INSTR_QUEUE_BYPASS_EN defined and count=0 and flush=0, present valid input lanes on dq_* in the same cycle (compacted), and enqueue only lanes not accepted by decode; without the macro, no combinational path runs from if_* to dq_*.

Structure
REQ-031 SHALL place the typedef fq_entry_t {pc, instr} and constant IQ_DEPTH in core_pkg.
REQ-032 SHALL place the storage array (FETCH_W write ports, FETCH_W read ports, no reset) in sub-module iq_storage; pointer, count and control logic stay in instr_queue.

Verification
REQ-033 Reset, then if_valid=11 with PCs 0x0/0x4 and dec_accept=00 -> next cycle dq_valid=11, dq_pc=0x0/0x4, count=2.
REQ-034 Fill with dec_accept=00: after 3 bundles count=6, fq_stall=1; 4th bundle -> count=8; 5th bundle -> lanes dropped, ovf_err=1 and sticky.
REQ-035 count=3, dec_accept=01 with if_valid=11 -> count=4, head advances by 1, dq_pc lane 0 shows the old second entry.
REQ-036 dec_accept=10 with dq_valid=11 -> no dequeue, count unchanged.
REQ-037 count=5 with flush=1 and if_valid=11 -> next cycle count=0, dq_valid=00, fq_stall=0; head and tail=0.
REQ-038 Push 20 bundles with dec_accept=11 continuous -> PCs emerge in order across pointer wrap, ovf_err=0; with INSTR_QUEUE_BYPASS_EN, dq_valid follows if_valid in the same cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and default sizes for the fetch-to-decode instruction queue.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package core_pkg;

    localparam int IQ_DEPTH   = 8;
    localparam int IQ_FETCH_W = 2;
    localparam int IQ_PC_W    = 32;
    localparam int IQ_INSTR_W = 32;

    // One queued instruction: its fetch PC and the raw instruction word
    typedef struct packed {
        logic [IQ_PC_W-1:0]    pc;
        logic [IQ_INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/iq_storage.sv
// Entry storage for instr_queue: PORTS write ports, PORTS fall-through read ports, no reset.
// Latency: writes are visible on the cycle after the edge; reads are combinational.
// Backpressure: none here; the caller guarantees distinct write addresses per cycle.
module iq_storage
    import core_pkg::*;
#(
    parameter int PORTS = IQ_FETCH_W,
    parameter int DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
)(
    input  logic                        clk,
    input  logic [PORTS-1:0]            wr_vld_i,
    input  logic [PORTS-1:0][PTR_W-1:0] wr_addr_i,
    input  fq_entry_t [PORTS-1:0]       wr_dat_i,
    input  logic [PORTS-1:0][PTR_W-1:0] rd_addr_i,
    output fq_entry_t [PORTS-1:0]       rd_dat_o
);

    fq_entry_t mem_q [DEPTH];

    // Write every enabled lane; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (wr_vld_i[i]) begin
                mem_q[wr_addr_i[i]] <= wr_dat_i[i];
            end
        end
    end

    // Fall-through read of the requested slots
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            rd_dat_o[i] = mem_q[rd_addr_i[i]];
        end
    end

endmodule

// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and decode, FETCH_W lanes in and out (INSTR_QUEUE_BYPASS_EN adds same-cycle bypass when empty).
// Latency: 1 cycle from if_valid to dq_valid; 0 cycles when empty with INSTR_QUEUE_BYPASS_EN.
// Backpressure: fq_stall from registered count leaves room for two bundles; overflowing lanes are dropped and flag ovf_err.
module instr_queue
    import core_pkg::*;
#(
    parameter int FETCH_W = IQ_FETCH_W,
    parameter int PC_W    = IQ_PC_W,
    parameter int INSTR_W = IQ_INSTR_W,
    parameter int DEPTH   = IQ_DEPTH
)(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [FETCH_W-1:0]              if_valid,
    input  logic [FETCH_W-1:0][PC_W-1:0]    if_pc,
    input  logic [FETCH_W-1:0][INSTR_W-1:0] if_instr,
    input  logic                            flush,
    output logic                            fq_stall,
    output logic [FETCH_W-1:0]              dq_valid,
    output logic [FETCH_W-1:0][PC_W-1:0]    dq_pc,
    output logic [FETCH_W-1:0][INSTR_W-1:0] dq_instr,
    input  logic [FETCH_W-1:0]              dec_accept,
    output logic                            ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(DEPTH - 2 * FETCH_W);

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 * FETCH_W) begin : g_bad_depth
        $error("instr_queue: DEPTH must be a power of 2 and at least 4*FETCH_W");
    end
    if (PC_W != IQ_PC_W || INSTR_W != IQ_INSTR_W) begin : g_bad_width
        $error("instr_queue: PC_W/INSTR_W must match fq_entry_t in core_pkg");
    end

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic             ovf_err_q;

    logic [FETCH_W-1:0]            cin_vld;
    fq_entry_t [FETCH_W-1:0]       cin_dat;
    logic [FETCH_W-1:0]            wr_en;
    logic [FETCH_W-1:0][PTR_W-1:0] wr_addr, rd_addr;
    fq_entry_t [FETCH_W-1:0]       wr_dat, rd_dat;
    logic                          byp, run, drop;
    int                            n_in, n_deq, n_adv, n_free, n_enq;

    iq_storage #(.PORTS(FETCH_W), .DEPTH(DEPTH)) u_storage (
        .clk       (clk),
        .wr_vld_i  (wr_en),
        .wr_addr_i (wr_addr),
        .wr_dat_i  (wr_dat),
        .rd_addr_i (rd_addr),
        .rd_dat_o  (rd_dat)
    );

    // Pack the valid fetch lanes into lane order so gaps never reach storage
    always_comb begin
        cin_vld = '0;
        cin_dat = '0;
        n_in    = 0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (if_valid[i]) begin
                for (int j = 0; j < FETCH_W; j++) begin
                    if (j == n_in) begin
                        cin_vld[j]       = 1'b1;
                        cin_dat[j].pc    = if_pc[i];
                        cin_dat[j].instr = if_instr[i];
                    end
                end
                n_in++;
            end
        end
    end

    // Head slots are read in order, oldest in lane 0
    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            rd_addr[i] = head_q + PTR_W'(i);
        end
    end

    // Present entries to decode, count what decode took, and place incoming lanes
    always_comb begin
        byp = 1'b0;
        for (int i = 0; i < FETCH_W; i++) begin
            dq_valid[i] = count_q > CNT_W'(i);
            dq_pc[i]    = rd_dat[i].pc;
            dq_instr[i] = rd_dat[i].instr;
        end
`ifdef INSTR_QUEUE_BYPASS_EN
        // Empty queue: hand the fetch bundle straight to decode this cycle
        byp = (count_q == '0) && !flush;
        if (byp) begin
            for (int i = 0; i < FETCH_W; i++) begin
                dq_valid[i] = cin_vld[i];
                dq_pc[i]    = cin_dat[i].pc;
                dq_instr[i] = cin_dat[i].instr;
            end
        end
`endif
        // Only the leading run of offered-and-accepted lanes is consumed
        n_deq = 0;
        run   = 1'b1;
        for (int i = 0; i < FETCH_W; i++) begin
            if (run && dq_valid[i] && dec_accept[i]) begin
                n_deq++;
            end else begin
                run = 1'b0;
            end
        end
        // Bypassed lanes taken by decode never touch storage, so head stays put
        n_adv  = byp ? 0 : n_deq;
        n_free = DEPTH - int'(count_q) + n_adv;
        wr_en   = '0;
        wr_addr = '0;
        wr_dat  = '0;
        n_enq   = 0;
        drop    = 1'b0;
        for (int j = 0; j < FETCH_W; j++) begin
            if (cin_vld[j] && !(byp && j < n_deq)) begin
                if (n_enq < n_free) begin
                    wr_en[j]   = !flush;
                    wr_addr[j] = tail_q + PTR_W'(n_enq);
                    wr_dat[j]  = cin_dat[j];
                    n_enq++;
                end else begin
                    drop = 1'b1;
                end
            end
        end
        count_d = CNT_W'(int'(count_q) + n_enq - n_adv);
        head_d  = head_q + PTR_W'(n_adv);
        tail_d  = tail_q + PTR_W'(n_enq);
    end

    // Pointer, count and sticky overflow state; reset beats flush beats normal traffic
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            ovf_err_q <= 1'b0;
        end else if (flush) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            ovf_err_q <= ovf_err_q | drop;
        end
    end

    assign fq_stall = count_q > STALL_TH;
    assign ovf_err  = ovf_err_q;

endmodule
